// File: rtl/swg_pkg.sv
// Shared constants and types for the sine wave generator PWM path.
// Sample and index widths match the lookup stage interface.
package swg_pkg;

  localparam int SWG_MAX_CODE = 2000;
  localparam int SWG_STEPS    = 64;
  localparam int SWG_IDX_W    = 10;
  localparam int SWG_SAMPLE_W = 16;

  typedef logic [SWG_SAMPLE_W-1:0] sample_t;
  typedef logic [5:0]              idx_t;

  function automatic sample_t sat(
    input sample_t s,
    input sample_t lim
  );
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/swg_tick_prescaler.sv
// Divides clk into PWM ticks; the counter is held at zero while disabled
// so a re-enable always starts on a full prescale interval.
module swg_tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  assign tick = en && (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/swg_pwm_driver.sv
// Drives the sine lookup index and turns each returned sample into one
// PWM period; the phase advances once per period boundary.
module swg_pwm_driver
  import swg_pkg::*;
#(
  parameter int MAX_CODE = SWG_MAX_CODE,
  parameter int PRESCALE = 1,
  parameter int STEPS    = SWG_STEPS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [5:0]              step,
  input  logic                    clr_clip,
  input  logic [SWG_SAMPLE_W-1:0] O,
  output logic [SWG_IDX_W-1:0]    T,
  output logic                    pwm,
  output logic                    sample_strobe,
  output logic                    cycle_done,
  output logic                    clip
);

  localparam int CW = $clog2(MAX_CODE);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CODE - 1);
  localparam sample_t MAX_S = SWG_SAMPLE_W'(MAX_CODE);
  localparam logic [6:0] STEPS_W = 7'(STEPS);
  localparam idx_t IDX_MASK = 6'(STEPS - 1);

  logic          tick;
  logic          boundary;
  logic [CW-1:0] cnt;
  idx_t          idx;
  sample_t       duty;
  logic [6:0]    idx_sum;
  logic          over;

  swg_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign boundary = tick && (cnt == CNT_LAST);
  assign idx_sum  = {1'b0, idx} + {1'b0, step};
  assign over     = O > MAX_S;
  assign T        = {{(SWG_IDX_W-6){1'b0}}, idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      idx           <= '0;
      duty          <= '0;
      pwm           <= 1'b0;
      sample_strobe <= 1'b0;
      cycle_done    <= 1'b0;
      clip          <= 1'b0;
    end else begin
      if (!en || boundary) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
      // T keeps the old index on this edge, so O belongs to it
      if (boundary) begin
        duty <= sat(O, MAX_S);
        idx  <= idx_sum[5:0] & IDX_MASK;
      end
      sample_strobe <= boundary;
      cycle_done    <= boundary && (idx_sum >= STEPS_W);
      if (boundary && over) begin
        clip <= 1'b1;
      end else if (clr_clip) begin
        clip <= 1'b0;
      end
      pwm <= en && ({{(SWG_SAMPLE_W-CW){1'b0}}, cnt} < duty);
    end
  end

endmodule

// File: tb/tb_swg_pwm_driver.sv
// Directed bench: sine LUT model feeding the default driver, plus a
// prescale-4 instance fed a constant sample.
module tb_swg_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  step;
  logic        clr_clip;
  logic [15:0] O;
  logic [9:0]  T;
  logic        pwm;
  logic        sample_strobe;
  logic        cycle_done;
  logic        clip;

  logic        en_b;
  logic [9:0]  t_b;
  logic        pwm_b;
  logic        ss_b;
  logic        cd_b;
  logic        clip_b;

  logic        use_force;
  logic [15:0] fval;

  int checks = 0;
  int errs   = 0;
  int hi, ss, ss_at, cd, cd_at;
  int hi2, ss2, ss2_at;
  int h;

  always #5 clk = ~clk;

  function automatic logic [15:0] lut(input logic [9:0] t);
    real a;
    a = 1000.0 * $sin(2.0 * 3.14159265358979 * real'(t[5:0]) / 64.0);
    return 16'(1000 + $rtoi(a + ((a >= 0.0) ? 0.5 : -0.5)));
  endfunction

  always_comb O = use_force ? fval : lut(T);

  swg_pwm_driver dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .step         (step),
    .clr_clip     (clr_clip),
    .O            (O),
    .T            (T),
    .pwm          (pwm),
    .sample_strobe(sample_strobe),
    .cycle_done   (cycle_done),
    .clip         (clip)
  );

  swg_pwm_driver #(
    .PRESCALE(4)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .en           (en_b),
    .step         (6'd0),
    .clr_clip     (1'b0),
    .O            (16'd500),
    .T            (t_b),
    .pwm          (pwm_b),
    .sample_strobe(ss_b),
    .cycle_done   (cd_b),
    .clip         (clip_b)
  );

  task automatic run1(input int n);
    hi = 0; ss = 0; ss_at = -1; cd = 0; cd_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (pwm) hi++;
      if (sample_strobe) begin ss++; ss_at = i; end
      if (cycle_done) begin cd++; cd_at = i; end
    end
  endtask

  task automatic run2(input int n);
    hi2 = 0; ss2 = 0; ss2_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (pwm_b) hi2++;
      if (ss_b) begin ss2++; ss2_at = i; end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (T !== 10'd0) begin errs++; $display("FAIL rst_T got %0d exp 0", T); end
    checks++;
    if (pwm !== 1'b0) begin errs++; $display("FAIL rst_pwm got %0b exp 0", pwm); end
    checks++;
    if (sample_strobe !== 1'b0) begin errs++; $display("FAIL rst_ss got %0b exp 0", sample_strobe); end
    checks++;
    if (cycle_done !== 1'b0) begin errs++; $display("FAIL rst_cd got %0b exp 0", cycle_done); end
    checks++;
    if (clip !== 1'b0) begin errs++; $display("FAIL rst_clip got %0b exp 0", clip); end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; step = 6'd1;
  endtask

  task automatic test_sine();
    run1(2000);
    checks++;
    if (hi != 0) begin errs++; $display("FAIL p1_high got %0d exp 0", hi); end
    checks++;
    if (T !== 10'd1) begin errs++; $display("FAIL p1_T got %0d exp 1", T); end
    checks++;
    if (sample_strobe !== 1'b1) begin errs++; $display("FAIL p1_ss got %0b exp 1", sample_strobe); end
    run1(2000);
    checks++;
    if (hi != 1000) begin errs++; $display("FAIL p2_high got %0d exp 1000", hi); end
    run1(2000);
    checks++;
    if (hi != 1098) begin errs++; $display("FAIL p3_high got %0d exp 1098", hi); end
    checks++;
    if (T !== 10'd3) begin errs++; $display("FAIL p3_T got %0d exp 3", T); end
  endtask

  task automatic test_wrap();
    step = 6'd57;
    run1(2000);
    checks++;
    if (T !== 10'd60) begin errs++; $display("FAIL w1_T got %0d exp 60", T); end
    checks++;
    if (cd != 0) begin errs++; $display("FAIL w1_cd got %0d exp 0", cd); end
    step = 6'd5;
    run1(2000);
    checks++;
    if (T !== 10'd1) begin errs++; $display("FAIL w2_T got %0d exp 1", T); end
    checks++;
    if (cd != 1 || cd_at != 2000) begin
      errs++; $display("FAIL w2_cd got n=%0d at %0d exp n=1 at 2000", cd, cd_at);
    end
    checks++;
    if (ss != 1 || ss_at != 2000) begin
      errs++; $display("FAIL w2_ss got n=%0d at %0d exp n=1 at 2000", ss, ss_at);
    end
    run1(2000);
    checks++;
    if (ss != 1 || ss_at != 2000) begin
      errs++; $display("FAIL w3_ss got n=%0d at %0d exp n=1 at 2000", ss, ss_at);
    end
    checks++;
    if (cd != 0 || T !== 10'd6) begin
      errs++; $display("FAIL w3_cd_T got cd=%0d T=%0d exp cd=0 T=6", cd, T);
    end
    step = 6'd0;
  endtask

  task automatic test_clip();
    use_force = 1'b1; fval = 16'd2500;
    run1(2000);
    checks++;
    if (clip !== 1'b1) begin errs++; $display("FAIL clip_set got %0b exp 1", clip); end
    run1(1999);
    h = hi;
    clr_clip = 1'b1;
    run1(1);
    h += hi;
    clr_clip = 1'b0;
    checks++;
    if (h != 2000) begin errs++; $display("FAIL clip_high got %0d exp 2000", h); end
    checks++;
    if (clip !== 1'b1) begin errs++; $display("FAIL clip_setwins got %0b exp 1", clip); end
    clr_clip = 1'b1;
    run1(1);
    clr_clip = 1'b0;
    checks++;
    if (clip !== 1'b0) begin errs++; $display("FAIL clip_clr got %0b exp 0", clip); end
    fval = 16'd800;
    run1(1999);
    checks++;
    if (ss_at != 1999 || clip !== 1'b0) begin
      errs++; $display("FAIL clip_800 got ss_at=%0d clip=%0b exp 1999 0", ss_at, clip);
    end
  endtask

  task automatic test_enable();
    run1(700);
    checks++;
    if (pwm !== 1'b1) begin errs++; $display("FAIL en_pre_pwm got %0b exp 1", pwm); end
    en = 1'b0; fval = 16'd300;
    run1(1);
    checks++;
    if (pwm !== 1'b0 || T !== 10'd6) begin
      errs++; $display("FAIL en_off got pwm=%0b T=%0d exp 0 6", pwm, T);
    end
    run1(10);
    checks++;
    if (hi != 0 || ss != 0) begin
      errs++; $display("FAIL en_idle got hi=%0d ss=%0d exp 0 0", hi, ss);
    end
    en = 1'b1;
    run1(2000);
    checks++;
    if (hi != 800) begin errs++; $display("FAIL en_held_duty got %0d exp 800", hi); end
    checks++;
    if (ss != 1 || ss_at != 2000) begin
      errs++; $display("FAIL en_boundary got n=%0d at %0d exp n=1 at 2000", ss, ss_at);
    end
  endtask

  task automatic test_async_reset();
    fval = 16'd2500;
    run1(2000);
    run1(1234);
    checks++;
    if (pwm !== 1'b1 || clip !== 1'b1 || T !== 10'd6) begin
      errs++; $display("FAIL ar_pre got pwm=%0b clip=%0b T=%0d exp 1 1 6", pwm, clip, T);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (T !== 10'd0 || pwm !== 1'b0 || clip !== 1'b0) begin
      errs++; $display("FAIL ar_clear got T=%0d pwm=%0b clip=%0b exp 0 0 0", T, pwm, clip);
    end
    checks++;
    if (sample_strobe !== 1'b0 || cycle_done !== 1'b0) begin
      errs++; $display("FAIL ar_strobes got %0b %0b exp 0 0", sample_strobe, cycle_done);
    end
    #1;
    rst = 1'b0; en = 1'b0; use_force = 1'b0;
  endtask

  task automatic test_prescale();
    @(posedge clk); #1;
    en_b = 1'b1;
    run2(8000);
    checks++;
    if (hi2 != 0 || ss2 != 1 || ss2_at != 8000) begin
      errs++; $display("FAIL ps_p1 got hi=%0d ss=%0d at %0d exp 0 1 8000", hi2, ss2, ss2_at);
    end
    run2(8000);
    checks++;
    if (hi2 != 2000) begin errs++; $display("FAIL ps_high got %0d exp 2000", hi2); end
    checks++;
    if (ss2 != 1 || ss2_at != 8000) begin
      errs++; $display("FAIL ps_period got n=%0d at %0d exp n=1 at 8000", ss2, ss2_at);
    end
    checks++;
    if (t_b !== 10'd0 || clip_b !== 1'b0) begin
      errs++; $display("FAIL ps_hold got T=%0d clip=%0b exp 0 0", t_b, clip_b);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = 6'd0; clr_clip = 1'b0;
    use_force = 1'b0; fval = 16'd0; en_b = 1'b0;
    test_reset();
    test_sine();
    test_wrap();
    test_clip();
    test_enable();
    test_async_reset();
    test_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/swg_pwm_driver.md
# swg_pwm_driver

Sequential driver that sits directly downstream of the sine lookup stage and closes the loop around it. It owns the sample index `T` fed to the lookup, consumes the 16-bit sample `O` it returns (0..2000, mid-scale 1000), and converts each sample into one PWM period whose high time equals the sample value in ticks. The block advances the phase once per PWM period, so output sine frequency is set by `step`, `PRESCALE` and `MAX_CODE`.

## Interface
- `MAX_CODE`, 2000: full-scale sample value; PWM period length in ticks.
- `PRESCALE`, 1: clocks per PWM tick (≥1).
- `STEPS`, 64: lookup entries per sine cycle (power of two).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: run enable.
- `step` in 6: phase increment per PWM period (0 = hold current sample).
- `clr_clip` in 1: clears sticky `clip`.
- `O` in 16: sample from the lookup stage, combinational in `T`.
- `T` out 10: sample index to the lookup stage; bits [9:6] always 0.
- `pwm` out 1: PWM output, registered.
- `sample_strobe` out 1: one-cycle pulse, new sample latched.
- `cycle_done` out 1: one-cycle pulse, index wrapped past `STEPS-1`.
- `clip` out 1: sticky, a sample exceeded `MAX_CODE`.

## Operation
- Registers: `presc` (0..PRESCALE-1), `cnt` (0..MAX_CODE-1), `idx` (6 b), `duty` (16 b), `pwm`, strobes, `clip`.
- Reset values: `idx`=0 (so `T`=0), `duty`=0, `cnt`=0, `presc`=0, `pwm`=0, `sample_strobe`=0, `cycle_done`=0, `clip`=0.
- Tick: `en` high and `presc`==PRESCALE-1; `presc` wraps to 0 on a tick, else increments while `en`.
- On tick: `cnt` increments; at `cnt`==MAX_CODE-1 it wraps to 0. That tick is the period boundary.
- At boundary, in the same edge:
  - `duty` ← min(`O`, MAX_CODE).
  - `idx` ← (`idx`+`step`) mod STEPS.
- `O` is sampled while `T` shows the old `idx`. `T` is therefore stable for a full period before its sample is used.
- At boundary, `clip` is set if `O` > MAX_CODE.
- `clr_clip` clears `clip`; if a set and a clear occur on the same edge, set wins.
- `step` is sampled only at the boundary; changes mid-period take effect at the next boundary.
- Every clock: `pwm` ← `en` && (`cnt` < `duty`).
  - `duty`=0 gives constant low.
  - `duty`=MAX_CODE gives constant high.
- `en` low:
  - `presc` and `cnt` clear to 0 synchronously; `pwm` goes to 0.
  - `idx`, `duty` and `clip` hold.
  - On re-enable, a full period starts at `cnt`=0 with the held `duty`.
- Async `rst` mid-period forces all reset values immediately, with no clock edge needed.

## Timing
- Period = MAX_CODE×PRESCALE clocks; defaults give 2000 clocks.
- `pwm` lags the `cnt`/`duty` registers by one clock. The high time of each period is exactly `duty`×PRESCALE clocks.
- `sample_strobe` and `cycle_done` are registered. They pulse high for one clock, in the cycle after the boundary edge.
- `cycle_done` fires when `idx`+`step` ≥ STEPS at a boundary.
- Full sine period = (STEPS/`step`)×period clocks, i.e. 128000 clocks at defaults with `step`=1.
- `T` changes only at boundary edges. The downstream lookup has a full period of settling time, so there is no combinational constraint beyond one period.

## Structure
- `swg_pkg` holds:
  - `SWG_MAX_CODE`=2000, `SWG_STEPS`=64, `SWG_IDX_W`=10, `SWG_SAMPLE_W`=16.
  - Sample type (16 b) and index type (6 b).
- Sub-module `swg_tick_prescaler`: `presc` counter with `en` clear, outputs `tick`.
- The top level instantiates `swg_tick_prescaler` plus the period counter, phase/duty registers and comparator.

## Test plan
- Reset → `T`=0, `pwm`=0, `sample_strobe`=0, `cycle_done`=0, `clip`=0. Assert `rst` asynchronously at `cnt`=1234 and confirm outputs clear without a clock edge.
- Defaults, `en`=1, `step`=1, bench LUT model attached:
  - First period: `pwm` constantly low (`duty`=0).
  - First boundary: latches 1000 and `T` goes to 1.
  - Next period: `pwm` high for exactly 1000 clocks.
  - The period after that: high for 1098 clocks.
- `step`=5 from `idx`=60:
  - `T` goes to 1 at the boundary.
  - `cycle_done` pulses once, one clock after the boundary.
  - `sample_strobe` pulses every 2000 clocks.
- Force `O`=2500:
  - `duty`=2000 and `pwm` high for the whole period; `clip`=1.
  - Pulse `clr_clip` on the same edge as a second clip: `clip` stays 1.
  - Pulse `clr_clip` alone: `clip` goes to 0.
- Drop `en` at `cnt`=700:
  - `pwm`=0 next clock, `cnt`=0, `T` unchanged.
  - Re-assert: next boundary after 2000 clocks, using the held `duty`.
- `PRESCALE`=4 with `O`=500: period 8000 clocks, `pwm` high 2000 clocks; `step`=0 keeps `T` constant.
